c1541_sd_arb: RTL
=================

C1541_SD_ARB -- requirements
Module: c1541_sd_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT_W, default 20: width of the ack watchdog counter.
REQ-002 The block SHALL have port sd_clk, input, 1: clock for all logic.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have ports c_lba0/c_lba1, input, 32: sector address requested by client 0/1.
REQ-005 The block SHALL have ports c_rd0/c_rd1 and c_wr0/c_wr1, input, 1: level read/write requests from client 0/1.
REQ-006 The block SHALL have ports c_ack0/c_ack1, output, 1: per-client transfer acknowledge.
REQ-007 The block SHALL have ports c_din0/c_din1, input, 8: client write data for the current sd_buff_addr.
REQ-008 The block SHALL have ports c_buff_wr0/c_buff_wr1, output, 1: per-client gated byte strobe.
REQ-009 The block SHALL have port sd_lba, output, 32: host sector address.
REQ-010 The block SHALL have ports sd_rd and sd_wr, output, 1: host requests.
REQ-011 The block SHALL have port sd_ack, input, 1: host transfer active.
REQ-012 The block SHALL have port sd_buff_wr, input, 1: host byte strobe.
REQ-013 The block SHALL have port sd_buff_din, output, 8: write data to host.
REQ-014 The block SHALL have port timeout_err, output, 1: one-cycle watchdog pulse.
REQ-015 sd_buff_addr and sd_buff_dout SHALL NOT pass through this block; they are wired straight from host to clients.

Function
REQ-016 The block SHALL implement FSM states IDLE, REQ, XFER, DONE.
REQ-017 In IDLE, a client is eligible if its rd|wr is high and its armed flag is 1.
- Arbitration: with exactly one eligible client, grant it.
- With both eligible, grant the client other than last_grant (round robin).
REQ-018 On grant, the block SHALL latch in the same cycle:
- grant index and lba.
- dir = wr (wr wins if rd and wr are both high).
- Clear the granted client's armed flag.
- Next state REQ.
REQ-019 In REQ, the block SHALL drive sd_lba = latched lba and sd_rd = !dir or sd_wr = dir.
- The watchdog counter increments each REQ cycle.
REQ-020 In REQ with sd_ack=1, the block SHALL deassert sd_rd/sd_wr in the next cycle and enter XFER.
REQ-021 In XFER, the block SHALL route strobes and data to the granted client only:
- c_ackN = sd_ack.
- c_buff_wrN = sd_buff_wr.
- sd_buff_din = c_dinN, combinational from the granted index.
- The other client's ack and buff_wr SHALL be 0.
REQ-022 In XFER with sd_ack=0, the block SHALL enter DONE and set last_grant to the granted index.
- DONE lasts exactly 1 cycle, then IDLE.
REQ-023 Outside XFER, all c_ack*, c_buff_wr* and sd_buff_din SHALL be 0.
REQ-024 A client's armed flag SHALL be set in any cycle its rd and wr are both low.
- This prevents re-granting a request still high from slow client-side synchronisers.
REQ-025 Watchdog: if the counter reaches 2^TIMEOUT_W-1 in REQ without sd_ack:
- Drop sd_rd/sd_wr, pulse timeout_err for 1 cycle, set last_grant and return to IDLE.
- The client stays disarmed until it releases its request.
REQ-026 sd_ack rising while in IDLE or DONE SHALL be ignored: no state change and no client ack.
REQ-027 A client request toggling during REQ/XFER SHALL NOT change the latched lba or dir.
REQ-028 Latency from request high in IDLE to sd_rd/sd_wr high SHALL be 2 cycles (grant register, then REQ output).

Reset
REQ-029 On reset, the block SHALL set:
- State IDLE, all outputs 0.
- sd_lba = 0 and watchdog = 0.
- last_grant = 1, so client 0 wins first contention.
- Both armed flags = 1.
REQ-030 Reset asserted in REQ or XFER SHALL abort immediately.
- Outputs go to 0 the next cycle.
- No DONE cycle and no timeout_err.

Verification
REQ-031 c_rd0=1, lba0=0x0000_0A53, host acks after 5 cycles, 512 sd_buff_wr strobes, then drops ack -> sd_rd high from cycle 2 until ack, sd_lba=0xA53, c_ack0 mirrors sd_ack, c_buff_wr0 gets 512 pulses, c_ack1/c_buff_wr1 stay 0.
REQ-032 c_rd0 and c_wr1 both raised in the same cycle after reset -> client 0 served first (read); client 1 served next with sd_wr=1, sd_lba=lba1.
REQ-033 Client 0 holds c_rd0 high for 10 cycles after its ack falls -> no second grant until c_rd0 is seen low, then a new request is granted.
REQ-034 c_wr1=1, c_din1=0x5A during XFER -> sd_buff_din=0x5A; after ack falls sd_buff_din=0.
REQ-035 TIMEOUT_W=4, c_rd0=1, no sd_ack -> sd_rd drops after 15 REQ cycles, timeout_err=1 for exactly 1 cycle, state IDLE.
REQ-036 reset asserted mid-XFER -> next cycle all outputs 0; a new c_rd1 then grants with 2-cycle latency.

Source files
------------

// File: rtl/c1541_sd_arb.sv
// c1541_sd_arb
// Shares one SD-card host sector port between two clients (e.g. two emulated
// 1541 drives). A client requests a sector with level rd/wr plus lba; the
// arbiter grants one client at a time, round robin on contention. It then
// forwards the request to the host and routes the host's ack, byte strobe and
// write data to the granted client only. sd_buff_addr and sd_buff_dout are
// wired host-to-clients outside this block.
//
// Ports
//   sd_clk, reset            clock, synchronous active-high reset
//   c_lbaN, c_rdN, c_wrN     client N sector address and level requests
//   c_ackN, c_buff_wrN       client N gated ack / byte strobe (XFER only)
//   c_dinN                   client N write data for the current buffer address
//   sd_lba, sd_rd, sd_wr     host request (registered)
//   sd_ack, sd_buff_wr       host transfer active / byte strobe
//   sd_buff_din              write data to host, muxed from the granted client
//   timeout_err              one-cycle pulse when the host never acks a request
module c1541_sd_arb #(
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic        sd_clk,
    input  logic        reset,
    input  logic [31:0] c_lba0,
    input  logic [31:0] c_lba1,
    input  logic        c_rd0,
    input  logic        c_rd1,
    input  logic        c_wr0,
    input  logic        c_wr1,
    output logic        c_ack0,
    output logic        c_ack1,
    input  logic [7:0]  c_din0,
    input  logic [7:0]  c_din1,
    output logic        c_buff_wr0,
    output logic        c_buff_wr1,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_t;

    state_t               state_q;
    logic                 grant_q;
    logic                 last_grant_q;
    logic                 dir_q;        // 1 = write
    logic [1:0]           armed_q;
    logic [31:0]          lba_q;
    logic [TIMEOUT_W-1:0] wd_q;
    logic                 sd_rd_q;
    logic                 sd_wr_q;
    logic                 timeout_q;

    logic        elig0;
    logic        elig1;
    logic        pick;
    logic        pick_wr;
    logic [31:0] pick_lba;
    logic        xfer;

    // A client must drop its request once before it can be granted again, so a
    // request still high after completion (slow synchronisers) is not re-served.
    assign elig0 = (c_rd0 | c_wr0) & armed_q[0];
    assign elig1 = (c_rd1 | c_wr1) & armed_q[1];

    always_comb begin
        pick = 1'b0;
        if (elig0 && elig1) begin
            pick = ~last_grant_q;
        end else if (elig1) begin
            pick = 1'b1;
        end
    end

    assign pick_wr  = pick ? c_wr1 : c_wr0;
    assign pick_lba = pick ? c_lba1 : c_lba0;

    always_ff @(posedge sd_clk) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            dir_q        <= 1'b0;
            armed_q      <= 2'b11;
            lba_q        <= '0;
            wd_q         <= '0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (!c_rd0 && !c_wr0) armed_q[0] <= 1'b1;
            if (!c_rd1 && !c_wr1) armed_q[1] <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (elig0 || elig1) begin
                        grant_q       <= pick;
                        lba_q         <= pick_lba;
                        dir_q         <= pick_wr;
                        armed_q[pick] <= 1'b0;
                        wd_q          <= '0;
                        state_q       <= StReq;
                    end
                end
                StReq: begin
                    if (sd_ack) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= StXfer;
                    end else if (wd_q == '1) begin
                        sd_rd_q      <= 1'b0;
                        sd_wr_q      <= 1'b0;
                        timeout_q    <= 1'b1;
                        last_grant_q <= grant_q;
                        state_q      <= StIdle;
                    end else begin
                        wd_q    <= wd_q + 1'b1;
                        sd_rd_q <= ~dir_q;
                        sd_wr_q <= dir_q;
                    end
                end
                StXfer: begin
                    if (!sd_ack) begin
                        last_grant_q <= grant_q;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign xfer = (state_q == StXfer);

    assign sd_lba      = lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign timeout_err = timeout_q;

    assign c_ack0      = xfer & ~grant_q & sd_ack;
    assign c_ack1      = xfer &  grant_q & sd_ack;
    assign c_buff_wr0  = xfer & ~grant_q & sd_buff_wr;
    assign c_buff_wr1  = xfer &  grant_q & sd_buff_wr;
    assign sd_buff_din = xfer ? (grant_q ? c_din1 : c_din0) : 8'h00;

endmodule
